// File: rtl/io_ccff_prog_ctrl.sv
// io_ccff_prog_ctrl: host-fed serial programming sequencer for an IO ccff chain.
// Optional CRC-16-CCITT check of the shifted stream: define CCFF_PROG_CRC_EN.
module io_ccff_prog_ctrl #(
    parameter int DATA_W        = 32,
    parameter int CHAIN_LEN     = 64,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              pReset,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int RW = $clog2(DATA_W + 1);
    localparam logic [31:0] CL = 32'(CHAIN_LEN);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SHIFT, S_CHECK, S_SETTLE, S_DONE, S_ERROR
    } state_t;

    state_t r_state, w_next;
    logic [15:0] r_cnt;
    logic [BW-1:0] r_bits;
    logic [RW-1:0] r_rem;
    logic [DATA_W-1:0] r_word;
    logic r_head;
    logic w_shift, w_more, w_room, w_hs, w_last;

    // a new word may land only while chain bits beyond the buffered ones remain
    assign w_shift = (r_state == S_SHIFT) && (r_rem != '0) && (32'(r_bits) < CL);
    assign w_more = (32'(r_bits) + 32'(r_rem)) < CL;
    assign w_room = (r_rem == '0) || ((r_rem == RW'(1)) && w_shift);
    assign w_last = w_shift && (32'(r_bits) == CL - 32'd1);
    assign w_hs = cfg_valid && cfg_ready;

`ifdef CCFF_PROG_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_nx;
    logic w_crc_ok;
    assign w_crc_nx = {r_crc[14:0], 1'b0} ^
                      ((r_crc[15] ^ ccff_head) ? 16'h1021 : 16'h0000);
    assign w_crc_ok = (cfg_data[15:0] == r_crc);
`endif

    always_comb begin
        cfg_ready = 1'b0;
        if (r_state == S_SHIFT) cfg_ready = w_room && w_more;
`ifdef CCFF_PROG_CRC_EN
        if (r_state == S_CHECK) cfg_ready = 1'b1;
`endif
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_CLEAR;
                S_CLEAR: if (r_cnt == RST_LAST) w_next = S_SHIFT;
`ifdef CCFF_PROG_CRC_EN
                S_SHIFT: if (w_last) w_next = S_CHECK;
                S_CHECK: if (w_hs) w_next = w_crc_ok ? S_SETTLE : S_ERROR;
`else
                S_SHIFT: if (w_last) w_next = S_SETTLE;
`endif
                S_SETTLE: if (r_cnt == SET_LAST) w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_cnt  <= '0;
            r_bits <= '0;
            r_rem  <= '0;
            r_word <= '0;
            r_head <= 1'b0;
        end else begin
            r_head <= ccff_head;
            if (w_next != r_state) r_cnt <= '0;
            else if (pReset || (r_state == S_SETTLE)) r_cnt <= r_cnt + 16'd1;
            if (r_state == S_CLEAR) begin
                r_bits <= '0;
                r_rem  <= '0;
                r_word <= '0;
            end else if (r_state == S_SHIFT) begin
                if (w_shift) r_bits <= r_bits + BW'(1);
                if (w_hs) begin
                    r_word <= cfg_data;
                    r_rem  <= RW'(DATA_W);
                end else if (w_shift) begin
                    r_word <= {r_word[DATA_W-2:0], 1'b0};
                    r_rem  <= r_rem - RW'(1);
                end
            end
        end
    end

`ifdef CCFF_PROG_CRC_EN
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) r_crc <= 16'hFFFF;
        else if (r_state == S_CLEAR) r_crc <= 16'hFFFF;
        else if (w_shift) r_crc <= w_crc_nx;
    end
    assign error = (r_state == S_ERROR);
`else
    assign error = 1'b0;
`endif

    assign ccff_shift_en = w_shift;
    assign ccff_head = w_shift ? r_word[DATA_W-1] : r_head;
    assign pReset = (r_state == S_CLEAR);
    assign IO_ISOL_N = (r_state == S_DONE);
    assign done = (r_state == S_DONE);
    assign busy = (r_state == S_CLEAR) || (r_state == S_SHIFT) ||
                  (r_state == S_CHECK) || (r_state == S_SETTLE);
endmodule

// File: tb/tb_io_ccff_prog_ctrl.sv
// tb_io_ccff_prog_ctrl: scoreboard bench for the ccff programming sequencer.
// Also exercises CCFF_PROG_CRC_EN builds when that macro is defined.
module tb_io_ccff_prog_ctrl;
    localparam int DW = 32;
    localparam int CL = 64;
    localparam int RC = 4;
    localparam int SC = 8;
    localparam int CL1 = 40;
`ifdef CCFF_PROG_CRC_EN
    localparam int GAP = SC + 1;
    localparam int NW = 3;
`else
    localparam int GAP = SC;
    localparam int NW = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, cfg_valid;
    logic [DW-1:0] cfg_data;
    logic cfg_ready, head, sen, prst, isol_n, busy, done, error;

    logic start1, abort1, cfg_valid1;
    logic [DW-1:0] cfg_data1;
    logic cfg_ready1, head1, sen1, prst1, isol_n1, busy1, done1, error1;

    io_ccff_prog_ctrl #(.DATA_W(DW), .CHAIN_LEN(CL), .RST_CYCLES(RC),
                        .SETTLE_CYCLES(SC)) dut (
        .prog_clk(clk), .pReset_n(rst_n), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(head), .ccff_shift_en(sen), .pReset(prst),
        .IO_ISOL_N(isol_n), .busy(busy), .done(done), .error(error));

    io_ccff_prog_ctrl #(.DATA_W(DW), .CHAIN_LEN(CL1), .RST_CYCLES(RC),
                        .SETTLE_CYCLES(SC)) dut1 (
        .prog_clk(clk), .pReset_n(rst_n), .start(start1), .abort(abort1),
        .cfg_data(cfg_data1), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
        .ccff_head(head1), .ccff_shift_en(sen1), .pReset(prst1),
        .IO_ISOL_N(isol_n1), .busy(busy1), .done(done1), .error(error1));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

`ifdef CCFF_PROG_CRC_EN
    logic [15:0] crc_xor = 16'h0000;
    function automatic logic [15:0] crc_fn(input logic [63:0] v, input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[15] ^ v[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction
`endif

    // reference model: expected chain bits, host words and per-word stalls
    bit exp_q[$];
    logic [DW-1:0] feed_w[$];
    int feed_s[$];
    int stall_cnt = 0;
    int hs_count = 0;
    int exp_stall = 0;
    int nshift = 0;
    int first_sh = 0;
    int last_sh = 0;
    bit done_seen = 0;
    logic prev_head = 1'b0;
    logic prev_rst = 1'b0;

    initial begin
        cfg_valid = 1'b0;
        cfg_data = '0;
        forever begin
            @(negedge clk);
            if (feed_w.size() == 0) begin
                cfg_valid = 1'b0;
            end else if (stall_cnt < feed_s[0]) begin
                cfg_valid = 1'b0;
                if (cfg_ready) stall_cnt++;
            end else begin
                cfg_valid = 1'b1;
                cfg_data = feed_w[0];
                if (cfg_ready && rst_n) begin
                    void'(feed_w.pop_front());
                    void'(feed_s.pop_front());
                    stall_cnt = 0;
                    hs_count++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sen) begin
                if (exp_q.size() == 0) begin
                    chk("extra_shift", 1, 0);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    chk("head_bit", head, e);
                end
                if (nshift == 0) first_sh = cyc;
                last_sh = cyc;
                nshift++;
            end else if (prev_rst) begin
                chk("head_hold", head, prev_head);
            end
            chk("isol_vs_done", isol_n, done);
            if (cfg_ready) chk("ready_busy", busy, 1);
            if (done) done_seen = 1;
        end
        prev_head = head;
        prev_rst = rst_n;
    end

    bit cap1[$];
    always @(negedge clk) if (rst_n && sen1) cap1.push_back(head1);

    task automatic prep(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input int s1);
        logic [2*DW-1:0] cat;
        @(posedge clk);
        #1;
        cat = {w0, w1};
        exp_q.delete();
        feed_w.delete();
        feed_s.delete();
        stall_cnt = 0;
        hs_count = 0;
        nshift = 0;
        exp_stall = s1;
        for (int i = 0; i < CL; i++) exp_q.push_back(cat[2*DW-1-i]);
        feed_w.push_back(w0);
        feed_s.push_back(0);
        feed_w.push_back(w1);
        feed_s.push_back(s1);
`ifdef CCFF_PROG_CRC_EN
        feed_w.push_back(DW'(crc_fn(cat, CL) ^ crc_xor));
        feed_s.push_back(0);
`endif
    endtask

    task automatic pulse_start();
        int n;
        logic first;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        first = 1'b0;
        for (int i = 0; i < RC + 2; i++) begin
            @(negedge clk);
            if (i == 0) begin
                first = prst;
                chk("isol_low_start", isol_n, 0);
                chk("flags_clear_start", {done, error}, 0);
            end
            if (prst) n++;
        end
        chk("preset_first", first, 1);
        chk("preset_len", n, RC);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("done", done, 1);
        chk("settle_gap", cyc - last_sh - 1, GAP);
        chk("shift_span", last_sh - first_sh + 1, CL + exp_stall);
        chk("bits_left", exp_q.size(), 0);
        chk("nshift", nshift, CL);
        chk("isol_release", isol_n, 1);
        chk("busy_in_done", busy, 0);
        chk("hs_count", hs_count, NW);
    endtask

    task automatic send1(input logic [DW-1:0] w, input int lim, output bit ok);
        cfg_data1 = w;
        cfg_valid1 = 1'b1;
        ok = 0;
        for (int t = 0; t < lim && !ok; t++) begin
            @(negedge clk);
            if (cfg_ready1) ok = 1;
        end
        @(posedge clk);
        #1 cfg_valid1 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        bit ok;
        logic [CL1-1:0] got1;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        cfg_valid1 = 1'b0;
        cfg_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {cfg_ready, head, sen, prst, isol_n, busy, done, error}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // directed words plus one surplus word that must never be taken
        prep(32'hA5A5_0F0F, 32'h1234_5678, 0);
        feed_w.push_back(32'hDEAD_BEEF);
        feed_s.push_back(0);
        pulse_start();
        wait_done();
        chk("surplus_kept", feed_w.size(), 1);
        repeat (5) @(negedge clk);
        chk("done_hold", {done, isol_n}, 2'b11);

        // host stall of five cycles before the second word
        prep(32'h0F0F_F0F0, 32'h3C3C_C3C3, 5);
        pulse_start();
        wait_done();

        for (int k = 0; k < 4; k++) begin
            prep($urandom, $urandom, $urandom_range(0, 6));
            pulse_start();
            wait_done();
        end

        // abort mid-shift, then a complete fresh run
        prep($urandom, $urandom, 0);
        pulse_start();
        t = 0;
        while (nshift < 20 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("abort_reach", nshift >= 20, 1);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        feed_w.delete();
        feed_s.delete();
        exp_q.delete();
        @(negedge clk);
        chk("abort_outs", {busy, cfg_ready, isol_n, sen, prst, done}, 0);
        prep($urandom, $urandom, 0);
        pulse_start();
        wait_done();

        // reset during SETTLE, then a complete fresh run
        prep($urandom, $urandom, 0);
        pulse_start();
        done_seen = 0;
        t = 0;
        while (nshift < CL && t < 300) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {cfg_ready, head, sen, prst, isol_n, busy, done, error}, 0);
        repeat (3) @(negedge clk);
        chk("no_done_after_rst", done_seen, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        prep($urandom, $urandom, 2);
        pulse_start();
        wait_done();

`ifdef CCFF_PROG_CRC_EN
        crc_xor = 16'h0001;
        prep($urandom, $urandom, 0);
        pulse_start();
        t = 0;
        while (!error && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("crc_error", error, 1);
        chk("crc_err_outs", {isol_n, busy, done}, 0);
        repeat (3) @(negedge clk);
        chk("crc_err_sticky", error, 1);
        crc_xor = 16'h0000;
        prep($urandom, $urandom, 0);
        pulse_start();
        wait_done();
`endif

        // 40-bit chain: only the top 8 bits of the second word reach it
        cap1.delete();
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        send1(32'hFFFF_FFFF, 100, ok);
        chk("w1_0_taken", ok, 1);
        send1(32'hAB00_0000, 100, ok);
        chk("w1_1_taken", ok, 1);
`ifdef CCFF_PROG_CRC_EN
        send1(DW'(crc_fn({24'h0, 32'hFFFF_FFFF, 8'hAB}, CL1)), 100, ok);
        chk("w1_crc_taken", ok, 1);
`endif
        send1(32'h5A5A_5A5A, 30, ok);
        chk("w1_extra_refused", ok, 0);
        t = 0;
        while (!done1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done1", {done1, isol_n1}, 2'b11);
        chk("len1", cap1.size(), CL1);
        got1 = '0;
        foreach (cap1[i]) got1 = {got1[CL1-2:0], cap1[i]};
        chk("bits1", got1, {32'hFFFF_FFFF, 8'hAB});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
